// File: rtl/slc3_mem_responder.sv
// SLC-3 SRAM strobe-bus responder: on-chip word store plus one I/O word
// (switches in, hex display out) behind the CPU's two-cycle read/write protocol.
module slc3_mem_responder #(
    parameter int          AW      = 10,
    parameter logic [15:0] IO_ADDR = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Mem_CE,
    input  logic        Mem_UB,
    input  logic        Mem_LB,
    input  logic        Mem_OE,
    input  logic        Mem_WE,
    input  logic [15:0] ADDR,
    input  logic [15:0] Data_in,
    output logic [15:0] Data_out,
    output logic        rd_valid,
    output logic        wr_done,
    input  logic [15:0] Switches,
    output logic [15:0] HEX_reg
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    typedef struct packed {
        logic          valid;
        logic          io;
        logic [AW-1:0] idx;
        logic [15:0]   data;
        logic          ub_n;
        logic          lb_n;
    } pend_t;

    state_t state, state_nxt;
    pend_t  pend;

    logic [15:0] mem [DEPTH];
    logic [15:0] sw_s1, sw_s2;

    logic ce_act, we_act, oe_act;
    logic do_read, do_cap, do_commit, do_drop;

    logic        cur_io;
    logic [15:0] rd_word;
    logic [15:0] rd_masked;

    logic commit_hi, commit_lo;

    assign ce_act = ~Mem_CE;
    assign we_act = ce_act & ~Mem_WE;
    assign oe_act = ce_act & ~Mem_OE;

    // Next-state and per-edge actions; Reset suppresses every side effect.
    always_comb begin
        state_nxt = state;
        do_read   = 1'b0;
        do_cap    = 1'b0;
        do_commit = 1'b0;
        do_drop   = 1'b0;
        unique case (state)
            IDLE: begin
                if (we_act) begin
                    state_nxt = WRITE;
                    do_cap    = 1'b1;
                end else if (oe_act) begin
                    state_nxt = READ;
                    do_read   = 1'b1;
                end
            end
            READ: begin
                if (!ce_act) begin
                    state_nxt = IDLE;
                end else if (we_act) begin
                    state_nxt = WRITE;
                    do_cap    = 1'b1;
                end else if (oe_act) begin
                    do_read   = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            WRITE: begin
                if (!ce_act) begin
                    state_nxt = IDLE;
                    do_drop   = 1'b1;
                end else if (we_act) begin
                    do_cap    = 1'b1;
                end else begin
                    state_nxt = IDLE;
                    do_commit = pend.valid;
                end
            end
            default: begin
                state_nxt = IDLE;
                do_drop   = 1'b1;
            end
        endcase
        if (Reset) begin
            state_nxt = IDLE;
            do_read   = 1'b0;
            do_cap    = 1'b0;
            do_commit = 1'b0;
            do_drop   = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= Switches;
            sw_s2 <= sw_s1;
        end
    end

    // Read path: I/O word never aliases into the store.
    assign cur_io  = (ADDR == IO_ADDR);
    assign rd_word = cur_io ? sw_s2 : mem[ADDR[AW-1:0]];

    always_comb begin
        rd_masked       = rd_word;
        if (Mem_UB) begin
            rd_masked[15:8] = 8'h00;
        end
        if (Mem_LB) begin
            rd_masked[7:0]  = 8'h00;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Data_out <= '0;
            rd_valid <= 1'b0;
            wr_done  <= 1'b0;
        end else begin
            if (do_read) begin
                Data_out <= rd_masked;
            end
            rd_valid <= do_read;
            wr_done  <= do_commit;
        end
    end

    // Pending write: last sample while WE is held low wins.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pend <= '0;
        end else if (do_cap) begin
            pend.valid <= 1'b1;
            pend.io    <= cur_io;
            pend.idx   <= ADDR[AW-1:0];
            pend.data  <= Data_in;
            pend.ub_n  <= Mem_UB;
            pend.lb_n  <= Mem_LB;
        end else if (do_commit || do_drop) begin
            pend <= '0;
        end
    end

    assign commit_hi = do_commit & ~pend.ub_n;
    assign commit_lo = do_commit & ~pend.lb_n;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            HEX_reg <= '0;
        end else if (pend.io) begin
            if (commit_hi) begin
                HEX_reg[15:8] <= pend.data[15:8];
            end
            if (commit_lo) begin
                HEX_reg[7:0]  <= pend.data[7:0];
            end
        end
    end

    // Store has no reset so it can map onto block RAM.
    always_ff @(posedge Clk) begin
        if (!pend.io) begin
            if (commit_hi) begin
                mem[pend.idx][15:8] <= pend.data[15:8];
            end
            if (commit_lo) begin
                mem[pend.idx][7:0]  <= pend.data[7:0];
            end
        end
    end

endmodule
